// File: rtl/csi2_modport_sink_if.sv
// rtl/csi2_modport_sink_if.sv - C-PHY lane bundle and decoded-word outputs
interface csi2_modport_sink_if #(
    parameter int NUM_LANES = 1
);
    logic [NUM_LANES-1:0][2:0] cphy_lane_signals;
    logic [NUM_LANES*16-1:0]   rx_word;
    logic [NUM_LANES-1:0]      rx_valid;
    logic [NUM_LANES-1:0]      rx_err;
    logic [NUM_LANES-1:0]      lane_active;

    modport master (
        output cphy_lane_signals,
        input  rx_word,
        input  rx_valid,
        input  rx_err,
        input  lane_active
    );

    modport slave (
        input  cphy_lane_signals,
        output rx_word,
        output rx_valid,
        output rx_err,
        output lane_active
    );
endinterface

// File: rtl/csi2_modport_sink.sv
// rtl/csi2_modport_sink.sv - C-PHY receive front end: wire-state decode and 7-symbol word packing
module csi2_modport_sink #(
    parameter int NUM_LANES = 1
) (
    input  logic                 tb_clk,
    input  logic                 reset,
    csi2_modport_sink_if.slave   lanes
);

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            logic [2:0]  r_samp;
            logic [2:0]  r_prev;
            logic        r_prev_ok;
            logic [2:0]  r_cnt;
            logic [16:0] r_acc;
            logic [15:0] r_word;
            logic        r_valid;
            logic        r_err;
            logic        r_active;

            logic        w_ok;
            logic [2:0]  w_idx;
            logic [2:0]  w_diff;
            logic [2:0]  w_sym;
            logic [16:0] w_v;

            logic [2:0]  w_prev_n;
            logic        w_prev_ok_n;
            logic [2:0]  w_cnt_n;
            logic [16:0] w_acc_n;
            logic [15:0] w_word_n;
            logic        w_valid_n;
            logic        w_err_n;

            // Map the sampled wire code onto its ring index; anything off the ring (incl. X/Z) is idle.
            always_comb begin
                w_ok  = 1'b1;
                w_idx = 3'd0;
                case (r_samp)
                    3'b100:  w_idx = 3'd0;
                    3'b110:  w_idx = 3'd1;
                    3'b010:  w_idx = 3'd2;
                    3'b011:  w_idx = 3'd3;
                    3'b001:  w_idx = 3'd4;
                    3'b101:  w_idx = 3'd5;
                    default: w_ok  = 1'b0;
                endcase
            end

            // Ring distance (1..5), symbol, and candidate base-5 accumulation.
            always_comb begin
                w_diff = (w_idx >= r_prev) ? (w_idx - r_prev) : (3'd6 - (r_prev - w_idx));
                w_sym  = w_diff - 3'd1;
                w_v    = (r_acc * 17'd5) + {14'd0, w_sym};
            end

            // Next-state for the lane: idle/abort, first state, hold, or symbol.
            always_comb begin
                w_prev_n    = r_prev;
                w_prev_ok_n = r_prev_ok;
                w_cnt_n     = r_cnt;
                w_acc_n     = r_acc;
                w_word_n    = r_word;
                w_valid_n   = 1'b0;
                w_err_n     = 1'b0;
                if (!w_ok) begin
                    w_prev_ok_n = 1'b0;
                    w_cnt_n     = 3'd0;
                    w_acc_n     = 17'd0;
                    w_err_n     = (r_cnt != 3'd0);
                end else if (!r_prev_ok) begin
                    w_prev_n    = w_idx;
                    w_prev_ok_n = 1'b1;
                end else if (w_idx != r_prev) begin
                    w_prev_n = w_idx;
                    if (r_cnt == 3'd6) begin
                        w_cnt_n = 3'd0;
                        w_acc_n = 17'd0;
                        if (!w_v[16]) begin
                            w_word_n  = w_v[15:0];
                            w_valid_n = 1'b1;
                        end else begin
                            w_err_n = 1'b1;
                        end
                    end else begin
                        w_cnt_n = r_cnt + 3'd1;
                        w_acc_n = w_v;
                    end
                end
            end

            // Sample stage and decode-stage state registers; reset discards any partial word.
            always_ff @(posedge tb_clk) begin
                if (reset) begin
                    r_samp    <= 3'b000;
                    r_prev    <= 3'd0;
                    r_prev_ok <= 1'b0;
                    r_cnt     <= 3'd0;
                    r_acc     <= 17'd0;
                    r_word    <= 16'd0;
                    r_valid   <= 1'b0;
                    r_err     <= 1'b0;
                    r_active  <= 1'b0;
                end else begin
                    r_samp    <= lanes.cphy_lane_signals[g];
                    r_prev    <= w_prev_n;
                    r_prev_ok <= w_prev_ok_n;
                    r_cnt     <= w_cnt_n;
                    r_acc     <= w_acc_n;
                    r_word    <= w_word_n;
                    r_valid   <= w_valid_n;
                    r_err     <= w_err_n;
                    r_active  <= w_ok;
                end
            end

            assign lanes.rx_word[16*g +: 16] = r_word;
            assign lanes.rx_valid[g]         = r_valid;
            assign lanes.rx_err[g]           = r_err;
            assign lanes.lane_active[g]      = r_active;
        end
    endgenerate

endmodule

// File: tb/tb_csi2_modport_sink.sv
// tb/tb_csi2_modport_sink.sv - scoreboard bench for csi2_modport_sink
module tb_csi2_modport_sink;
    localparam int NL = 4;

    typedef struct {
        int          lane;
        bit          is_err;
        logic [15:0] word;
        int          cyc;
    } exp_t;

    logic tb_clk = 1'b0;
    logic reset  = 1'b1;
    logic [NL-1:0][2:0] drv;

    csi2_modport_sink_if #(.NUM_LANES(NL)) bus ();
    assign bus.cphy_lane_signals = drv;

    csi2_modport_sink #(.NUM_LANES(NL)) dut (
        .tb_clk (tb_clk),
        .reset  (reset),
        .lanes  (bus)
    );

    always #5 tb_clk = ~tb_clk;

    int cyc = 0;
    always @(posedge tb_clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;
    exp_t exp_q[$];

    logic [2:0]  codes [6];
    int          cur [NL];
    logic [15:0] last_word [NL];
    int          sy [NL][7];
    logic [15:0] ew [NL];
    bit          ee [NL];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: any pulse on a lane must match the oldest expectation for that lane.
    always @(negedge tb_clk) begin
        if (!reset) begin
            for (int l = 0; l < NL; l++) begin
                if (bus.rx_valid[l] || bus.rx_err[l]) begin
                    int idx;
                    idx = -1;
                    for (int j = 0; j < exp_q.size(); j++)
                        if (idx < 0 && exp_q[j].lane == l) idx = j;
                    if (idx < 0) begin
                        chk($sformatf("unexpected_pulse_lane%0d", l), {30'd0, bus.rx_err[l], bus.rx_valid[l]}, 32'd0);
                    end else begin
                        exp_t e;
                        e = exp_q[idx];
                        exp_q.delete(idx);
                        chk($sformatf("kind_lane%0d", l), {30'd0, bus.rx_err[l], bus.rx_valid[l]},
                            e.is_err ? 32'd2 : 32'd1);
                        chk($sformatf("word_lane%0d", l), {16'd0, bus.rx_word[16*l +: 16]}, {16'd0, e.word});
                        chk($sformatf("latency_lane%0d", l), cyc, e.cyc);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic set_lane(input int l, input int s0, input int s1, input int s2, input int s3,
                            input int s4, input int s5, input int s6, input logic [15:0] w, input bit e);
        sy[l][0] = s0; sy[l][1] = s1; sy[l][2] = s2; sy[l][3] = s3;
        sy[l][4] = s4; sy[l][5] = s5; sy[l][6] = s6;
        ew[l] = w;
        ee[l] = e;
    endtask

    task automatic send_words(input logic [NL-1:0] en, input int hold_k);
        for (int l = 0; l < NL; l++) if (en[l]) drv[l] = codes[cur[l]];
        tick();
        tick();
        for (int l = 0; l < NL; l++) if (en[l]) chk($sformatf("active_start_lane%0d", l), {31'd0, bus.lane_active[l]}, 32'd1);
        for (int k = 0; k < 7; k++) begin
            for (int l = 0; l < NL; l++) begin
                if (en[l]) begin
                    cur[l] = (cur[l] + sy[l][k] + 1) % 6;
                    drv[l] = codes[cur[l]];
                    if (k == 6) begin
                        exp_q.push_back('{l, ee[l], ee[l] ? last_word[l] : ew[l], cyc + 2});
                        if (!ee[l]) last_word[l] = ew[l];
                    end
                end
            end
            tick();
            if (k == hold_k) tick();
        end
    endtask

    task automatic abort_word(input int l, input int nsym, input logic [2:0] idle_code);
        drv[l] = codes[cur[l]];
        tick();
        tick();
        for (int k = 0; k < nsym; k++) begin
            cur[l] = (cur[l] + 1) % 6;
            drv[l] = codes[cur[l]];
            tick();
        end
        drv[l] = idle_code;
        exp_q.push_back('{l, 1'b1, last_word[l], cyc + 2});
        tick();
        tick();
        chk($sformatf("active_after_abort_lane%0d", l), {31'd0, bus.lane_active[l]}, 32'd0);
    endtask

    task automatic drain();
        int budget;
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            tick();
            budget--;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        codes[0] = 3'b100; codes[1] = 3'b110; codes[2] = 3'b010;
        codes[3] = 3'b011; codes[4] = 3'b001; codes[5] = 3'b101;
        for (int l = 0; l < NL; l++) begin
            cur[l] = 0;
            last_word[l] = 16'h0000;
        end

        // Reset with undriven wires
        drv   = 'x;
        reset = 1'b1;
        tick(); tick(); tick();
        chk("reset_rx_word", bus.rx_word, 32'd0);
        chk("reset_rx_valid", {28'd0, bus.rx_valid}, 32'd0);
        chk("reset_rx_err", {28'd0, bus.rx_err}, 32'd0);
        chk("reset_lane_active", {28'd0, bus.lane_active}, 32'd0);
        drv   = '0;
        reset = 1'b0;
        tick(); tick(); tick();
        chk("idle_lane_active", {28'd0, bus.lane_active}, 32'd0);

        // Seven +1 steps -> 0x0000
        set_lane(0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1'b0);
        send_words(4'b0001, -1);
        // 4,0,4,4,1,2,0 -> 0xFFFF, then 0,...,0,1 -> 0x0001
        set_lane(0, 4, 0, 4, 4, 1, 2, 0, 16'hFFFF, 1'b0);
        send_words(4'b0001, -1);
        set_lane(0, 0, 0, 0, 0, 0, 0, 1, 16'h0001, 1'b0);
        send_words(4'b0001, -1);
        // Seven symbol-4 steps -> 78124, overflow error, word held
        set_lane(0, 4, 4, 4, 4, 4, 4, 4, 16'h0000, 1'b1);
        send_words(4'b0001, -1);

        // Abort after 3 symbols with 111, then a fresh word
        abort_word(0, 3, 3'b111);
        set_lane(0, 1, 2, 3, 0, 4, 1, 2, 16'h5D31, 1'b0);
        send_words(4'b0001, -1);
        // Idle in the slot where the 7th symbol would land
        abort_word(0, 6, 3'b000);

        // Four lanes concurrently with a one-cycle hold after the 3rd symbol
        set_lane(0, 1, 2, 3, 0, 4, 1, 2, 16'h5D31, 1'b0);
        set_lane(1, 4, 0, 4, 4, 1, 2, 0, 16'hFFFF, 1'b0);
        set_lane(2, 0, 0, 0, 0, 0, 0, 1, 16'h0001, 1'b0);
        set_lane(3, 0, 0, 0, 0, 1, 0, 0, 16'h0019, 1'b0);
        send_words(4'b1111, 2);
        drain();
        chk("multi_rx_word", bus.rx_word, 64'h0019_0001_FFFF_5D31);

        // Reset mid-word discards silently
        drv[2] = codes[cur[2]];
        tick(); tick();
        for (int k = 0; k < 3; k++) begin
            cur[2] = (cur[2] + 1) % 6;
            drv[2] = codes[cur[2]];
            tick();
        end
        reset = 1'b1;
        tick(); tick();
        drv   = '0;
        reset = 1'b0;
        for (int l = 0; l < NL; l++) last_word[l] = 16'h0000;
        tick(); tick(); tick();
        chk("post_reset_rx_word", bus.rx_word, 32'd0);
        chk("post_reset_rx_err", {28'd0, bus.rx_err}, 32'd0);

        drain();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
